fetch_unit: RTL

//  Instruction-fetch initiator for the rv32i core. Owns the PC and drives the

---
 rtl/rv32_pkg.sv | 15 +
 rtl/fetch_unit.sv | 72 +++++++
 2 files changed

// File: rtl/rv32_pkg.sv
// Shared rv32i core types and constants.
package rv32_pkg;

    typedef logic [31:0] word_t;

    localparam word_t RV32_NOP         = 32'h0000_0013;
    localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_BOOT,
        FETCH_RUN,
        FETCH_HALT
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: owns the PC, reads a combinational imem and
// presents {pc, instr} to decode through a one-entry valid/ready stage.
module fetch_unit
    import rv32_pkg::*;
#(
    parameter word_t RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        halted
);

    fetch_state_t state, state_nxt;
    word_t        pc;
    logic         load;

    assign imem_addr = {pc[31:2], 2'b00};
    assign halted    = (state == FETCH_HALT);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        if (redirect_valid) begin
            // Redirect never loads; it only leaves BOOT early.
            if (state == FETCH_BOOT) state_nxt = FETCH_RUN;
        end else begin
            case (state)
                FETCH_BOOT: state_nxt = halt_req ? FETCH_HALT : FETCH_RUN;
                FETCH_RUN: begin
                    if (halt_req) state_nxt = FETCH_HALT;
                    else          load      = !if_valid || if_ready;
                end
                FETCH_HALT: if (!halt_req) state_nxt = FETCH_RUN;
                default:    state_nxt = FETCH_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH_BOOT;
            pc       <= RESET_PC;
            if_valid <= 1'b0;
            if_instr <= RV32_NOP;
            if_pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (redirect_valid) begin
                pc       <= {redirect_pc[31:2], 2'b00};
                if_valid <= 1'b0;
            end else if (load) begin
                pc       <= imem_addr + 32'd4;
                if_valid <= 1'b1;
                if_instr <= imem_data;
                if_pc    <= imem_addr;
            end else if (if_valid && if_ready) begin
                // Transfer with no refill (halting or halted).
                if_valid <= 1'b0;
            end
        end
    end

endmodule
